// File: rtl/sync_ctrl.sv
// Block-synchronisation controller: streams one 2N+L sample block into the estimator, waits for its
// result and hands it to the consumer. Define SYNC_TIMEOUT_EN to compile in the DRAIN watchdog.
module sync_ctrl #(
    parameter int N         = 256,
    parameter int L         = 16,
    parameter int DRAIN_MAX = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        dp_in_valid,
    output logic        dp_clr,
    input  logic        dp_res_valid,
    input  logic [7:0]  dp_theta,
    input  logic [20:0] dp_eps,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_theta,
    output logic [20:0] m_eps,
    output logic [15:0] sym_cnt,
    output logic        err,
    output logic        timeout
);

    localparam int                BLOCK_LEN = 2 * N + L;
    localparam int                CNT_W     = 10;
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(BLOCK_LEN - 1);

    typedef enum logic [1:0] {
        CLR    = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        HOLD   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         theta_q, theta_d;
    logic [20:0]        eps_q, eps_d;
    logic [15:0]        sym_q, sym_d;
    logic               err_q, err_d;
    logic               tmo_q, tmo_d;
    logic               wd_expire;

`ifdef SYNC_TIMEOUT_EN
    localparam int WD_W = $clog2(DRAIN_MAX + 1);
    logic [WD_W-1:0] wd_q;

    // Counts cycles spent in DRAIN; restarts whenever the FSM is elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q <= '0;
        end else if (state_q != DRAIN) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 1'b1;
        end
    end

    assign wd_expire = (state_q == DRAIN) && (wd_q == WD_W'(DRAIN_MAX - 1));
`else
    assign wd_expire = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLR;
            cnt_q   <= '0;
            theta_q <= '0;
            eps_q   <= '0;
            sym_q   <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            theta_q <= theta_d;
            eps_q   <= eps_d;
            sym_q   <= sym_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        theta_d = theta_q;
        eps_d   = eps_q;
        sym_d   = sym_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        s_ready = 1'b0;
        dp_clr  = 1'b0;
        m_valid = 1'b0;

        case (state_q)
            CLR: begin
                dp_clr  = 1'b1;
                cnt_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // A real result on the expiry cycle takes priority over the watchdog.
                if (dp_res_valid) begin
                    theta_d = dp_theta;
                    eps_d   = dp_eps;
                    state_d = HOLD;
                end else if (wd_expire) begin
                    theta_d = '0;
                    eps_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    sym_d   = sym_q + 1'b1;
                    tmo_d   = 1'b0;
                    state_d = CLR;
                end
            end
            default: begin
                state_d = CLR;
            end
        endcase

        if (dp_res_valid && (state_q != DRAIN)) begin
            err_d = 1'b1;
        end

        dp_in_valid = s_valid & s_ready;
    end

    assign m_theta = theta_q;
    assign m_eps   = eps_q;
    assign sym_cnt = sym_q;
    assign err     = err_q;
    assign timeout = tmo_q;

endmodule

// File: tb/tb_sync_ctrl.sv
// Bench for sync_ctrl: transaction-level model checked every cycle, directed scenarios with literal
// expectations, then randomized traffic. Honours SYNC_TIMEOUT_EN the same way the design does.
module tb_sync_ctrl;

    localparam int TOTAL     = 528;
    localparam int DRAIN_MAX = 64;

    logic        clk          = 1'b0;
    logic        rst          = 1'b1;
    logic        s_valid      = 1'b0;
    logic        dp_res_valid = 1'b0;
    logic [7:0]  dp_theta     = '0;
    logic [20:0] dp_eps       = '0;
    logic        m_ready      = 1'b0;

    logic        s_ready, dp_in_valid, dp_clr, m_valid, err, timeout;
    logic [7:0]  m_theta;
    logic [20:0] m_eps;
    logic [15:0] sym_cnt;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 1'b0;

    sync_ctrl #(.N(256), .L(16), .DRAIN_MAX(DRAIN_MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .dp_in_valid  (dp_in_valid),
        .dp_clr       (dp_clr),
        .dp_res_valid (dp_res_valid),
        .dp_theta     (dp_theta),
        .dp_eps       (dp_eps),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_theta      (m_theta),
        .m_eps        (m_eps),
        .sym_cnt      (sym_cnt),
        .err          (err),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Block-level model: a block is "clear cycle, TOTAL accepted samples, wait for result, hold result".
    bit          md_clr;
    int          md_acc;
    bit          md_held;
    logic [7:0]  md_theta;
    logic [20:0] md_eps;
    logic [15:0] md_sym;
    bit          md_err;
    bit          md_tmo;
    int          md_wait;
    logic        md_drain;

    assign md_drain = !md_clr && (md_acc == TOTAL) && !md_held;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            md_clr   <= 1'b1;
            md_acc   <= 0;
            md_held  <= 1'b0;
            md_theta <= '0;
            md_eps   <= '0;
            md_sym   <= '0;
            md_err   <= 1'b0;
            md_tmo   <= 1'b0;
            md_wait  <= 0;
        end else begin
            if (dp_res_valid && !md_drain) md_err <= 1'b1;
            if (md_clr) begin
                md_clr  <= 1'b0;
                md_acc  <= 0;
                md_wait <= 0;
            end else if (md_acc < TOTAL) begin
                if (s_valid) md_acc <= md_acc + 1;
                md_wait <= 0;
            end else if (!md_held) begin
                if (dp_res_valid) begin
                    md_held  <= 1'b1;
                    md_theta <= dp_theta;
                    md_eps   <= dp_eps;
                end
`ifdef SYNC_TIMEOUT_EN
                else if (md_wait + 1 == DRAIN_MAX) begin
                    md_held  <= 1'b1;
                    md_theta <= '0;
                    md_eps   <= '0;
                    md_tmo   <= 1'b1;
                end else begin
                    md_wait <= md_wait + 1;
                end
`endif
            end else if (m_ready) begin
                md_held <= 1'b0;
                md_clr  <= 1'b1;
                md_acc  <= 0;
                md_sym  <= md_sym + 16'd1;
                md_tmo  <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("mdl_s_ready",     s_ready,     !md_clr && (md_acc < TOTAL));
            check("mdl_dp_in_valid", dp_in_valid, s_valid && !md_clr && (md_acc < TOTAL));
            check("mdl_dp_clr",      dp_clr,      md_clr);
            check("mdl_m_valid",     m_valid,     md_held);
            check("mdl_m_theta",     m_theta,     md_theta);
            check("mdl_m_eps",       m_eps,       md_eps);
            check("mdl_sym_cnt",     sym_cnt,     md_sym);
            check("mdl_err",         err,         md_err);
            check("mdl_timeout",     timeout,     md_tmo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Streams until s_ready falls after having been high; returns accepted-sample count.
    task automatic run_block(input bit toggle, input int spur_at, output int pulses);
        bit seen;
        bit done;
        seen   = 1'b0;
        done   = 1'b0;
        pulses = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            tick();
            if (toggle) s_valid = ~s_valid;
            dp_res_valid = (i == spur_at);
            sample();
            if (dp_in_valid) pulses++;
            if (s_ready) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        dp_res_valid = 1'b0;
        check("block_end_reached", done, 1'b1);
    endtask

    // Presents a result on the second DRAIN cycle; returns at the first HOLD cycle.
    task automatic give_result(input logic [7:0] th, input logic [20:0] ep);
        tick();
        dp_res_valid = 1'b1;
        dp_theta     = th;
        dp_eps       = ep;
        tick();
        dp_res_valid = 1'b0;
        sample();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        int p;

        @(posedge clk);
        chk_on = 1'b1;
        sample();
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_sym_cnt", sym_cnt, 16'd0);
        check("rst_timeout", timeout, 1'b0);
        tick();
        rst     = 1'b0;
        s_valid = 1'b1;
        m_ready = 1'b1;
        sample();
        check("first_cycle_dp_clr", dp_clr, 1'b1);

        // Full block with continuous samples, then a known result.
        run_block(1'b0, -1, p);
        check("block1_len", p, TOTAL);
        check("block1_drain_ready", s_ready, 1'b0);
        repeat (3) begin
            tick();
            sample();
            check("drain_no_accept", dp_in_valid, 1'b0);
        end
        give_result(8'h2A, 21'h0ABCD);
        check("res_m_valid", m_valid, 1'b1);
        check("res_m_theta", m_theta, 8'h2A);
        check("res_m_eps",   m_eps,   21'h0ABCD);
        check("res_sym_pre", sym_cnt, 16'd0);
        tick();
        sample();
        check("xfer_sym_cnt", sym_cnt, 16'd1);
        check("xfer_m_valid", m_valid, 1'b0);
        check("xfer_dp_clr",  dp_clr,  1'b1);

        // Consumer stalls for 10 HOLD cycles.
        m_ready = 1'b0;
        run_block(1'b0, -1, p);
        check("block2_len", p, TOTAL);
        give_result(8'h55, 21'h12345);
        for (int k = 1; k <= 10; k++) begin
            check("hold_m_valid", m_valid, 1'b1);
            check("hold_m_theta", m_theta, 8'h55);
            check("hold_m_eps",   m_eps,   21'h12345);
            check("hold_no_accept", dp_in_valid, 1'b0);
            if (k < 10) begin
                tick();
                sample();
            end
        end
        tick();
        m_ready = 1'b1;
        sample();
        check("hold11_m_valid", m_valid, 1'b1);
        check("hold11_sym",     sym_cnt, 16'd1);
        tick();
        sample();
        check("hold_xfer_m_valid", m_valid, 1'b0);
        check("hold_xfer_sym",     sym_cnt, 16'd2);

        // Toggling s_valid plus a stray result during STREAM.
        check("err_before", err, 1'b0);
        run_block(1'b1, 100, p);
        check("block3_len", p, TOTAL);
        check("err_after_spur", err, 1'b1);
        check("spur_no_m_valid", m_valid, 1'b0);
        give_result(8'h01, 21'h1FFFFF);
        check("block3_m_eps", m_eps, 21'h1FFFFF);
        tick();
        sample();
        check("block3_sym", sym_cnt, 16'd3);
        check("err_sticky", err, 1'b1);

        // Reset part-way through a block.
        s_valid = 1'b1;
        repeat (300) tick();
        rst = 1'b1;
        sample();
        check("midrst_m_valid", m_valid, 1'b0);
        check("midrst_s_ready", s_ready, 1'b0);
        check("midrst_sym",     sym_cnt, 16'd0);
        check("midrst_err",     err,     1'b0);
        tick();
        rst = 1'b0;
        sample();
        check("midrst_dp_clr", dp_clr, 1'b1);
        run_block(1'b0, -1, p);
        check("block4_len", p, TOTAL);

        // No result arrives in DRAIN.
`ifdef SYNC_TIMEOUT_EN
        for (int k = 1; k <= DRAIN_MAX; k++) begin
            tick();
            sample();
            if (k < DRAIN_MAX) begin
                check("wd_wait_m_valid", m_valid, 1'b0);
            end else begin
                check("wd_m_valid", m_valid, 1'b1);
                check("wd_timeout", timeout, 1'b1);
                check("wd_m_theta", m_theta, 8'h00);
                check("wd_m_eps",   m_eps,   21'h0);
            end
        end
        tick();
        sample();
        check("wd_xfer_timeout", timeout, 1'b0);
        check("wd_xfer_sym",     sym_cnt, 16'd1);
`else
        repeat (100) begin
            tick();
            sample();
            check("nowd_m_valid", m_valid, 1'b0);
            check("nowd_timeout", timeout, 1'b0);
        end
        give_result(8'hAA, 21'h00F0F);
        check("nowd_late_theta", m_theta, 8'hAA);
        tick();
        sample();
        check("nowd_xfer_sym", sym_cnt, 16'd1);
`endif

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 6000; c++) begin
            tick();
            rst          = ($urandom_range(0, 1999) == 0);
            s_valid      = ($urandom_range(0, 3) != 0);
            m_ready      = ($urandom_range(0, 2) != 0);
            dp_res_valid = ($urandom_range(0, 39) == 0);
            dp_theta     = 8'($urandom);
            dp_eps       = 21'($urandom);
        end
        tick();
        rst          = 1'b0;
        dp_res_valid = 1'b0;
        sample();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
